// File: rtl/mips_defs.sv
// Shared definitions for the FPGA_MIPS fetch path: reset/NOP defaults, fetch FSM
// state encodings and the word-alignment helper.
package mips_defs;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF    = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_incrementer.sv
// Next-sequential PC: adds one instruction word, wrapping modulo 2^32.
module pc_fetch_unit_incrementer (
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    assign pc_out = pc_in + 32'd4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests and registers the
// fetched word into the IF/ID boundary, honouring stalls and branch/jump redirects.
module pc_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0]  if_instr_q, if_instr_d;

    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         accept;

    pc_fetch_unit_incrementer u_incrementer (
        .pc_in  (pc_q),
        .pc_out (pc_plus4)
    );

    assign redirect    = branch_taken | jump;
    assign redirect_pc = word_align(branch_taken ? branch_target : jump_target);
    assign imem_req    = (state_q == ST_FETCH) & ~stall & ~redirect;
    assign imem_addr   = pc_q;
    assign accept      = imem_req & imem_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: state_d = stall ? ST_HOLD : ST_FETCH;
                ST_HOLD:  state_d = stall ? ST_HOLD : ST_FETCH;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    // Redirect beats stall; stall freezes everything and ignores imem_ready.
    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_instr_d    = if_instr_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (accept) begin
                pc_d          = pc_plus4;
                if_valid_d    = 1'b1;
                if_pc_d       = pc_q;
                if_pc_plus4_d = pc_plus4;
                if_instr_d    = imem_rdata;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pc_q          <= word_align(RESET_VECTOR);
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'h0;
            if_pc_plus4_q <= 32'h0;
            if_instr_q    <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;

endmodule
